// File: rtl/clken_nco_gen.sv
// Multi-channel NCO clock-enable generator: per-channel phase accumulators emit one-cycle ce strobes.
// Optional CLKEN_SQUARE_OUT_EN adds a registered accumulator-MSB square wave output (sq).
module clken_nco_lane #(
  parameter int ACC_W = 32
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cap,
  input  logic             load,
  input  logic             step,
  input  logic             run,
  input  logic [ACC_W-1:0] inc_in,
  input  logic [ACC_W-1:0] phase_in,
  output logic             ce
`ifdef CLKEN_SQUARE_OUT_EN
  , output logic           sq
`endif
);
  logic [ACC_W-1:0] inc_q, phase_q, acc;
  logic [ACC_W:0]   sum;

  // Carry out of the add is the strobe; the ACC_W-bit wrap keeps the long-run rate exact.
  assign sum = {1'b0, acc} + {1'b0, inc_q};

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      inc_q   <= '0;
      phase_q <= '0;
      acc     <= '0;
      ce      <= 1'b0;
`ifdef CLKEN_SQUARE_OUT_EN
      sq      <= 1'b0;
`endif
    end else begin
      if (cap) begin
        inc_q   <= inc_in;
        phase_q <= phase_in;
      end
      if (load)      acc <= phase_q;
      else if (step) acc <= sum[ACC_W-1:0];
      ce <= run & sum[ACC_W];
`ifdef CLKEN_SQUARE_OUT_EN
      sq <= run & sum[ACC_W-1];
`endif
    end
  end
endmodule

module clken_nco_gen #(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 32,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [NUM_CH*ACC_W-1:0] cfg_inc,
  input  logic [NUM_CH*ACC_W-1:0] cfg_phase,
  output logic [NUM_CH-1:0]       ce,
  output logic                    locked
`ifdef CLKEN_SQUARE_OUT_EN
  , output logic [NUM_CH-1:0]     sq
`endif
);
  localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SETTLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             accept, load, step, run;

  assign accept = cfg_valid & cfg_ready;
  assign load   = (state == LOAD);
  assign step   = (state == SETTLE) || (state == RUN);
  // Strobes are suppressed on the accept edge so nothing leaks from the old config.
  assign run    = (state == RUN) && !accept;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state     <= LOAD;
          cfg_ready <= 1'b0;
        end
        LOAD: begin
          cnt   <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(LOCK_CYCLES - 1)) begin
            state     <= RUN;
            locked    <= 1'b1;
            cfg_ready <= 1'b1;
          end
        end
        RUN: if (accept) begin
          state     <= LOAD;
          locked    <= 1'b0;
          cfg_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clken_nco_lane #(.ACC_W(ACC_W)) u_lane (
      .refclk   (refclk),
      .rst      (rst),
      .cap      (accept),
      .load     (load),
      .step     (step),
      .run      (run),
      .inc_in   (cfg_inc[i*ACC_W +: ACC_W]),
      .phase_in (cfg_phase[i*ACC_W +: ACC_W]),
      .ce       (ce[i])
`ifdef CLKEN_SQUARE_OUT_EN
      , .sq     (sq[i])
`endif
    );
  end
endmodule

// File: tb/tb_clken_nco_gen.sv
// Directed bench for clken_nco_gen at ACC_W=8, NUM_CH=2, LOCK_CYCLES=4; sq checks need CLKEN_SQUARE_OUT_EN.
module tb_clken_nco_gen;
  localparam int NUM_CH = 2;
  localparam int ACC_W  = 8;
  localparam int LOCK   = 4;

  logic                    refclk, rst, cfg_valid, cfg_ready, locked;
  logic [NUM_CH*ACC_W-1:0] cfg_inc, cfg_phase;
  logic [NUM_CH-1:0]       ce;
`ifdef CLKEN_SQUARE_OUT_EN
  logic [NUM_CH-1:0]       sq;
`endif

  int n_cmp = 0;
  int n_err = 0;

  clken_nco_gen #(.NUM_CH(NUM_CH), .ACC_W(ACC_W), .LOCK_CYCLES(LOCK)) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_inc   (cfg_inc),
    .cfg_phase (cfg_phase),
    .ce        (ce),
    .locked    (locked)
`ifdef CLKEN_SQUARE_OUT_EN
    , .sq      (sq)
`endif
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge refclk);
    #1;
  endtask

  // Accept a config, then walk LOAD/SETTLE with a bounded wait for locked.
  task automatic cfg(input string tag, input int i0, input int p0, input int i1, input int p1);
    int lat, rdy_low, settle_ce;
    cfg_inc   = {8'(i1), 8'(i0)};
    cfg_phase = {8'(p1), 8'(p0)};
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
    chk({tag, "_locked_drop"}, 32'(locked), 0);
    chk({tag, "_ce_drop"}, 32'(ce), 0);
    rdy_low   = cfg_ready ? 0 : 1;
    settle_ce = 0;
    lat       = 99;
    for (int k = 1; k <= 20; k++) begin
      // Offer junk while not ready: must be ignored.
      if (k == 1) begin
        cfg_valid = 1'b1;
        cfg_inc   = '1;
        cfg_phase = '1;
      end else cfg_valid = 1'b0;
      tick;
      if (locked) begin
        lat = k;
        break;
      end
      if (!cfg_ready) rdy_low++;
      settle_ce += $countones(ce);
`ifdef CLKEN_SQUARE_OUT_EN
      chk({tag, "_sq_settle"}, 32'(sq), 0);
`endif
    end
    cfg_valid = 1'b0;
    chk({tag, "_lock_lat"}, lat, 5);
    chk({tag, "_rdy_low"}, rdy_low, 5);
    chk({tag, "_settle_ce"}, settle_ce, 0);
    chk({tag, "_rdy_at_lock"}, 32'(cfg_ready), 1);
  endtask

  task automatic run_count(input int n, output int c0, output int c1, output int f0,
                           output int c1_8, output int unlocked);
    c0 = 0; c1 = 0; f0 = 0; c1_8 = 0; unlocked = 0;
    for (int j = 1; j <= n; j++) begin
      tick;
      if (!locked) unlocked++;
      if (ce[0]) begin
        c0++;
        if (f0 == 0) f0 = j;
      end
      if (ce[1]) begin
        c1++;
        if (j <= 8) c1_8++;
      end
    end
  endtask

  initial begin
    int c0, c1, f0, c1_8, ul, f0_base;
    rst = 1'b1; cfg_valid = 1'b0; cfg_inc = '0; cfg_phase = '0;
    #23;
    chk("rst_ready", 32'(cfg_ready), 1);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_ce", 32'(ce), 0);
    rst = 1'b0;
    tick; tick;
    chk("idle_locked", 32'(locked), 0);

    // ch0 inc=64, ch1 inc=96, zero phase
    cfg("base", 64, 0, 96, 0);
    run_count(256, c0, c1, f0, c1_8, ul);
    chk("base_c0", c0, 64);
    chk("base_c1", c1, 96);
    chk("base_first0", f0, 4);
    chk("base_c1_per8", c1_8, 3);
    chk("base_unlocked", ul, 0);
    f0_base = f0;

    // Reconfigure in RUN: ch0 at half rate
    cfg("half", 128, 0, 96, 0);
    run_count(256, c0, c1, f0, c1_8, ul);
    chk("half_c0", c0, 128);
    chk("half_first0", f0, 2);
    chk("half_c1", c1, 96);

    // Start phase 192 moves the ch0 train 3 cycles earlier
    cfg("phase", 64, 192, 96, 0);
    run_count(256, c0, c1, f0, c1_8, ul);
    chk("phase_first0", f0, 1);
    chk("phase_shift", f0_base - f0, 3);
    chk("phase_c0", c0, 64);

`ifdef CLKEN_SQUARE_OUT_EN
    cfg("sq", 64, 0, 96, 0);
    for (int j = 1; j <= 8; j++) begin
      tick;
      chk("sq_wave", 32'(sq[0]), ((j % 4) == 2 || (j % 4) == 3) ? 1 : 0);
    end
`endif

    // Boundary increments
    cfg("edge", 0, 0, 255, 0);
    run_count(256, c0, c1, f0, c1_8, ul);
    chk("edge_c0", c0, 0);
    chk("edge_c1", c1, 255);

    // Async reset mid-RUN, between clock edges
    #2 rst = 1'b1;
    #1;
    chk("arst_ce", 32'(ce), 0);
    chk("arst_locked", 32'(locked), 0);
    chk("arst_ready", 32'(cfg_ready), 1);
    #3 rst = 1'b0;
    run_count(8, c0, c1, f0, c1_8, ul);
    chk("post_rst_ce", c0 + c1, 0);
    chk("post_rst_unlocked", ul, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
